data_cal_seq: RTL and testbench

// Initiator and checker for the data_cal nibble-sum unit. Accepts a 16-bit word on a valid/ready input.

---
 rtl/data_cal_pkg.sv | 21 ++
 rtl/data_cal_exp.sv | 22 ++
 rtl/data_cal_seq.sv | 138 +++++++++++++
 tb/tb_data_cal_seq.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cal_pkg.sv
// Shared types and constants for the data_cal sequencer: FSM state encoding,
// field widths and status-bit positions.
package data_cal_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NIB_W    = 4;
  localparam int RES_W    = 5;
  localparam int N_SEL    = 4;
  localparam int WORD_W   = 16;
  localparam int OUT_W    = N_SEL * RES_W;
  localparam int ERR_W    = 2;
  localparam int ERR_TMO  = 0;
  localparam int ERR_MISM = 1;

endpackage

// File: rtl/data_cal_exp.sv
// Expected data_cal results for one word: slot 0 is the low nibble, slot k adds
// nibble k to the low nibble. Sums are 5 bits wide, so they never overflow.
module data_cal_exp
  import data_cal_pkg::*;
(
  input  logic [WORD_W-1:0]            word,
  output logic [N_SEL-1:0][RES_W-1:0]  exp_v
);

  logic [RES_W-1:0] base;

  assign base = RES_W'(word[NIB_W-1:0]);

  always_comb begin
    exp_v    = '0;
    exp_v[0] = base;
    for (int i = 1; i < N_SEL; i++) begin
      exp_v[i] = base + RES_W'(word[i*NIB_W +: NIB_W]);
    end
  end

endmodule

// File: rtl/data_cal_seq.sv
// Drives one accepted word through data_cal with sel 0..3, gathers the four
// results and returns them packed with timeout/mismatch status.
module data_cal_seq
  import data_cal_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic [WORD_W-1:0]   cal_d,
  output logic [1:0]          cal_sel,
  output logic                cal_en,
  input  logic [RES_W-1:0]    cal_out,
  input  logic                cal_validout,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  output logic [ERR_W-1:0]    out_err,
  input  logic                out_ready,
  output state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE; out_valid is high only in DONE and
  // out_data/out_err stay frozen until out_ready is seen.

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  state_e                      state_q, state_d;
  logic [WORD_W-1:0]           word_q;
  logic [1:0]                  issue_cnt_q;
  logic [2:0]                  rsp_cnt_q;
  logic [TMO_W-1:0]            tmo_cnt_q;
  logic [N_SEL-1:0][RES_W-1:0] slot_q;
  logic                        mism_q;
  logic                        tmo_q;

  logic [N_SEL-1:0][RES_W-1:0] exp_v;
  logic                        accept;
  logic                        collect;
  logic                        rsp_take;
  logic                        rsp_last;
  logic                        rsp_miss;
  logic                        tmo_hit;
  logic                        release_out;
  logic [1:0]                  rsp_idx;

  data_cal_exp u_exp (
    .word  (word_q),
    .exp_v (exp_v)
  );

  assign rsp_idx     = rsp_cnt_q[1:0];
  assign accept      = in_valid && in_ready;
  assign collect     = (state_q == ISSUE) || (state_q == WAIT);
  assign rsp_take    = collect && cal_validout && (rsp_cnt_q < 3'd4);
  assign rsp_last    = rsp_take && (rsp_cnt_q == 3'd3);
  assign rsp_miss    = (cal_out != exp_v[rsp_idx]);
  // A response on the limit cycle postpones the timeout, so a 4th result
  // landing exactly on the limit completes cleanly.
  assign tmo_hit     = (state_q == WAIT) && (tmo_cnt_q >= TMO_LIM) && !rsp_take;
  assign release_out = (state_q == DONE) && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE: begin
        if (rsp_last)                  state_d = DONE;
        else if (issue_cnt_q == 2'd3)  state_d = WAIT;
      end
      WAIT:    if (rsp_last || tmo_hit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    cal_en    = (state_q == ISSUE);
    cal_sel   = cal_en ? issue_cnt_q : 2'd0;
    cal_d     = word_q;
    out_valid = (state_q == DONE);
    out_data  = '0;
    out_err   = '0;
    if (state_q == DONE) begin
      out_data          = slot_q;
      out_err[ERR_TMO]  = tmo_q;
      out_err[ERR_MISM] = mism_q;
    end
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      issue_cnt_q <= '0;
      rsp_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      slot_q      <= '0;
      mism_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) word_q <= in_data;
      if (state_q == ISSUE) issue_cnt_q <= issue_cnt_q + 2'd1;

      if (state_q == ISSUE && state_d == WAIT) begin
        tmo_cnt_q <= '0;
      end else if (state_q == WAIT && tmo_cnt_q != TMO_MAX) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end

      if (rsp_take) begin
        slot_q[rsp_idx] <= cal_out;
        rsp_cnt_q       <= rsp_cnt_q + 3'd1;
        if (rsp_miss) mism_q <= 1'b1;
      end
      if (tmo_hit) tmo_q <= 1'b1;

      if (release_out) begin
        issue_cnt_q <= '0;
        rsp_cnt_q   <= '0;
        tmo_cnt_q   <= '0;
        slot_q      <= '0;
        mism_q      <= 1'b0;
        tmo_q       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_cal_seq.sv
// Bench for data_cal_seq: a configurable data_cal responder, a transaction-level
// model of the expected result and timing, and a per-cycle compare process.
module tb_data_cal_seq;
  import data_cal_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready;
  logic [15:0] cal_d;
  logic [1:0]  cal_sel;
  logic        cal_en;
  logic [4:0]  cal_out = 5'h0;
  logic        cal_validout = 1'b0;
  logic        out_valid;
  logic [19:0] out_data;
  logic [1:0]  out_err;
  logic        out_ready = 1'b0;
  state_e      dbg_state;

  data_cal_seq #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .cal_d        (cal_d),
    .cal_sel      (cal_sel),
    .cal_en       (cal_en),
    .cal_out      (cal_out),
    .cal_validout (cal_validout),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_ready    (out_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- responder (stand-in for data_cal) ----------------
  int         lat[4];
  int         keep = 4;
  int         corrupt_idx = -1;
  logic [4:0] corrupt_val = 5'h0;
  int         due_q[$];
  logic [4:0] val_q[$];
  int         late_seen = 0;

  function automatic logic [4:0] nib_sum(input logic [15:0] d, input int sel);
    int base, nib;
    base = int'(d & 16'hF);
    nib  = (sel == 0) ? 0 : int'((d >> (4 * sel)) & 16'hF);
    return 5'(base + nib);
  endfunction

  always @(negedge clk) begin
    logic [4:0] v;
    cal_validout = 1'b0;
    cal_out      = 5'h0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      cal_validout = 1'b1;
      cal_out      = val_q[0];
      void'(due_q.pop_front());
      void'(val_q.pop_front());
      if (!rst && dbg_state == IDLE) late_seen++;
    end
    if (cal_en && int'(cal_sel) < keep) begin
      v = nib_sum(cal_d, int'(cal_sel));
      if (int'(cal_sel) == corrupt_idx) v = corrupt_val;
      due_q.push_back(cyc + lat[cal_sel]);
      val_q.push_back(v);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [19:0] exp_q[$];
  logic [1:0]  exp_err_q[$];
  int          exp_done_q[$];
  int          exp_acc_q[$];
  logic [15:0] cur_word = 16'h0;
  bit          head_seen = 0;
  int          first_cyc = 0;
  int          n_words = 0;
  int          n_results = 0;
  logic [19:0] last_data = '0;
  logic [1:0]  last_err = '0;
  int          last_lat = 0;

  // Transaction-level view: beat i (issued at a+1+i) answers at a+1+i+lat[i];
  // answers up to the timeout limit fill slots in order; DONE follows the 4th
  // answer or the limit cycle.
  function automatic void model(input logic [15:0] d, input int a);
    int         limit, n, last, t;
    logic [4:0] slots[4];
    logic [4:0] v, e;
    bit         mism, tmo;
    limit = a + 5 + TMO - 1;
    n = 0; last = 0; mism = 0;
    for (int i = 0; i < 4; i++) slots[i] = 5'h0;
    for (int i = 0; i < keep; i++) begin
      t = a + 1 + i + lat[i];
      if (t <= limit) begin
        e = {1'b0, d[3:0]} + ((i == 0) ? 5'd0 : {1'b0, d[4*i +: 4]});
        v = (i == corrupt_idx) ? corrupt_val : e;
        if (v != e) mism = 1;
        slots[n] = v;
        n++;
        last = t;
      end
    end
    tmo = (n < 4);
    exp_q.push_back({slots[3], slots[2], slots[1], slots[0]});
    exp_err_q.push_back({mism, tmo});
    exp_done_q.push_back(tmo ? limit + 1 : last + 1);
    exp_acc_q.push_back(a);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); exp_err_q.delete(); exp_done_q.delete(); exp_acc_q.delete();
      head_seen = 0;
    end else begin
      if (in_valid && in_ready) begin
        model(in_data, cyc);
        cur_word = in_data;
        n_words++;
      end
      if (cal_en) check("cal_d", cal_d, cur_word);
      if (exp_q.size() == 0) begin
        check("out_valid_idle", out_valid, 1'b0);
      end else if (out_valid) begin
        if (!head_seen) begin
          check("done_cycle", cyc, exp_done_q[0]);
          head_seen = 1;
          first_cyc = cyc;
        end
        check("out_data", out_data, exp_q[0]);
        check("out_err", out_err, exp_err_q[0]);
        if (out_ready) begin
          last_data = out_data;
          last_err  = out_err;
          last_lat  = first_cyc - exp_acc_q[0];
          void'(exp_q.pop_front()); void'(exp_err_q.pop_front());
          void'(exp_done_q.pop_front()); void'(exp_acc_q.pop_front());
          head_seen = 0;
          n_results++;
        end
      end else if (!head_seen && cyc == exp_done_q[0]) begin
        check("out_valid_at_done", out_valid, 1'b1);
      end
    end
  end

  // ---------------- drivers ----------------
  bit or_random = 0;
  bit or_force  = 1;
  always @(posedge clk) begin
    #1;
    out_ready = or_random ? 1'($urandom_range(0, 1)) : 1'(or_force);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int l0, input int l1, input int l2, input int l3,
                     input int k, input int ci, input logic [4:0] cv);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    keep = k; corrupt_idx = ci; corrupt_val = cv;
  endtask

  task automatic send_word(input logic [15:0] w, input bit hold);
    bit acc;
    acc = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        break;
      end
    end
    check("accept_in_time", acc, 1'b1);
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget);
    int  start;
    bit  got;
    start = n_results;
    got = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (n_results > start) begin
        got = 1;
        break;
      end
    end
    check("result_in_time", got, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          b2b_start;
    bit          seen;
    logic [15:0] w;
    int          l0, l1, l2, l3;

    cfg(1, 1, 1, 1, 4, -1, 5'h0);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 20'h0);
    check("rst_out_err", out_err, 2'b00);
    check("rst_cal_en", cal_en, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // basic word, 1-cycle responder
    send_word(16'hF1A3, 0);
    wait_result(100);
    check("basic_data", last_data, {5'h12, 5'h04, 5'h0D, 5'h03});
    check("basic_err", last_err, 2'b00);
    check("basic_latency", last_lat, 6);

    // backpressure in DONE
    or_force = 0;
    send_word(16'h5A5A, 0);
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    check("bp_reach_done", seen, 1'b1);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, {5'h0F, 5'h14, 5'h0F, 5'h0A});
      check("bp_in_ready", in_ready, 1'b0);
    end
    or_force = 1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1'b0);
    check("bp_release_valid", out_valid, 1'b1);
    @(negedge clk);
    check("bp_after_in_ready", in_ready, 1'b1);
    check("bp_after_valid", out_valid, 1'b0);
    tick();

    // timeout with only two answers
    cfg(1, 1, 1, 1, 2, -1, 5'h0);
    send_word(16'hBEEF, 0);
    wait_result(100);
    check("tmo_err", last_err, 2'b01);
    check("tmo_slots_hi", last_data[19:10], 10'h0);
    check("tmo_slots_lo", last_data[9:0], {5'h1D, 5'h0F});
    check("tmo_latency", last_lat, 21);

    // mismatch on slot 2
    cfg(1, 1, 1, 1, 4, 2, 5'h1F);
    send_word(16'h0000, 0);
    wait_result(100);
    check("mism_err", last_err, 2'b10);
    check("mism_slot2", last_data[14:10], 5'h1F);
    check("mism_data", last_data, {5'h00, 5'h1F, 5'h00, 5'h00});

    // reset mid-ISSUE with late responses
    cfg(3, 3, 3, 3, 4, -1, 5'h0);
    send_word(16'h7777, 0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (cal_en && cal_sel == 2'd2) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("rst_mid_found_sel2", seen, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_in_ready_low", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_state", dbg_state, IDLE);
    check("rst_mid_in_ready", in_ready, 1'b1);
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_out_data", out_data, 20'h0);
    check("rst_mid_out_err", out_err, 2'b00);
    check("rst_mid_cal_en", cal_en, 1'b0);
    check("rst_mid_cal_sel", cal_sel, 2'd0);
    check("rst_mid_cal_d", cal_d, 16'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("late_ignored_state", dbg_state, IDLE);
      check("late_ignored_in_ready", in_ready, 1'b1);
    end
    check("late_rsp_delivered", late_seen > 0, 1'b1);
    cfg(1, 1, 1, 1, 4, -1, 5'h0);
    send_word(16'h1111, 0);
    wait_result(100);
    check("after_rst_data", last_data, {5'h02, 5'h02, 5'h02, 5'h01});
    check("after_rst_err", last_err, 2'b00);

    // 4th answer on the limit cycle, then one cycle past it
    cfg(1, 1, 1, 16, 4, -1, 5'h0);
    send_word(16'h2468, 0);
    wait_result(100);
    check("edge_ok_err", last_err, 2'b00);
    check("edge_ok_data", last_data, {5'h0A, 5'h0C, 5'h0E, 5'h08});
    check("edge_ok_latency", last_lat, 21);
    cfg(1, 1, 1, 17, 4, -1, 5'h0);
    send_word(16'h2468, 0);
    wait_result(100);
    check("edge_late_err", last_err, 2'b01);
    check("edge_late_data", last_data, {5'h00, 5'h0C, 5'h0E, 5'h08});
    repeat (4) tick();

    // back-to-back words with in_valid held high
    cfg(1, 1, 1, 1, 4, -1, 5'h0);
    or_random = 1;
    b2b_start = n_results;
    for (int i = 0; i < 6; i++) send_word(16'($urandom), 1);
    in_valid = 1'b0;
    for (int n = 0; n < 400 && n_results - b2b_start < 6; n++) tick();
    check("b2b_results", n_results - b2b_start, 6);

    // randomized words, latencies, drops and corruption
    for (int i = 0; i < 30; i++) begin
      l0 = $urandom_range(1, 4);
      l1 = l0 + $urandom_range(0, 2);
      l2 = l1 + $urandom_range(0, 2);
      l3 = l2 + $urandom_range(0, 3);
      cfg(l0, l1, l2, l3,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
          5'($urandom));
      w = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      send_word(w, 0);
      wait_result(200);
    end

    repeat (4) tick();
    check("all_results_returned", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #300000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
